sum_operand_feeder: RTL and testbench
=====================================

# sum_operand_feeder

- Upstream stage of the registered adder.
- Accepts operand words on one valid/ready stream in A, B, A, B… order and pairs them.
- Buffers the pairs in a small FIFO.
- Presents one pair per cycle on the adder's `sum_in1`/`sum_in2`/`sum_in_en` inputs, so a bursty or narrow-rate producer can keep the adder fed without back-to-back operand pairing logic in the producer.

## Interface

Parameters:
- `BUS_WIDTH`, default 32: operand width; must match the adder's `BUS_WIDTH`.
- `FIFO_DEPTH`, default 4: pair buffer entries; a power of two, at least 2.

Ports:
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `arst` input, 1 bit: reset, asynchronous, active-high.
- `op_in` input, `BUS_WIDTH` bits: operand word.
- `op_in_valid` input, 1 bit: `op_in` is valid.
- `op_in_ready` output, 1 bit: the block accepts `op_in` this cycle (combinational).
- `op_clear` input, 1 bit: synchronous flush.
- `issue_hold` input, 1 bit: suppresses issue to the adder while high.
- `sum_in1` output, `BUS_WIDTH` bits: operand A to the adder (registered).
- `sum_in2` output, `BUS_WIDTH` bits: operand B to the adder (registered).
- `sum_in_en` output, 1 bit: pair-valid strobe to the adder (registered).
- `fifo_count` output, `$clog2(FIFO_DEPTH+1)` bits: occupied entries (registered).

## Operation

Capture FSM, two states:
- `S_A`: waiting for operand A.
  - `op_in_ready` = 1.
  - On transfer (`op_in_valid && op_in_ready`): `a_reg <= op_in`, go to `S_B`.
- `S_B`: A held, waiting for operand B.
  - `op_in_ready` = `!full || pop`.
  - On transfer: push `{a_reg, op_in}` into the FIFO, go to `S_A`.
- `op_in_ready` is forced to 0 while `arst` or `op_clear` is high.

FIFO:
- `FIFO_DEPTH` entries of `2*BUS_WIDTH` bits.
- Write and read pointers wrap modulo `FIFO_DEPTH`.
- `full` = (`fifo_count == FIFO_DEPTH`); `empty` = (`fifo_count == 0`).
- Push and pop in the same cycle: `fifo_count` unchanged.
- Push while full is allowed only when a pop occurs in the same cycle; this is already guaranteed by `op_in_ready`.
- No overflow or underflow is possible; the bench asserts this.

Issue:
- `pop` = `!empty && !issue_hold && !op_clear`.
- On `pop`: at the next edge `sum_in1` <= head A, `sum_in2` <= head B, `sum_in_en` <= 1.
- Without `pop`: `sum_in_en` <= 0; `sum_in1`/`sum_in2` hold their last values.
- Issue rate is at most one pair per cycle.
- The adder always accepts, so there is no backpressure from downstream beyond `issue_hold`.

`op_clear`, synchronous, highest priority:
- Next edge: FSM to `S_A`, half-captured A discarded, FIFO pointers and `fifo_count` set to 0, `sum_in_en` set to 0.
- `sum_in1`/`sum_in2` hold.
- Nothing is pushed or popped in the clear cycle.

Reset (`arst` high, immediate):
- State `S_A`; `a_reg`, pointers, `fifo_count`, `sum_in1`, `sum_in2`, `sum_in_en` all 0.
- `op_in_ready` = 0 while `arst` is high; it becomes 1 in the first cycle after release.
- Reset mid-pair discards the A word and all buffered pairs.

## Timing

- Empty FIFO, `issue_hold` = 0, B accepted at edge N:
  - The pair is written at edge N.
  - `pop` is asserted in cycle N..N+1.
  - `sum_in_en` = 1 after edge N+1.
  - Latency from B handshake to issue: 1 cycle. The adder result follows one cycle later (`sum_out_en`).
- Back-to-back stream with valid held high:
  - One pair is accepted every 2 cycles.
  - `sum_in_en` pulses every other cycle.
- FIFO full in `S_B` with `issue_hold` = 1: `op_in_ready` = 0. It returns to 1 in the same cycle that `issue_hold` falls.
- `issue_hold` takes effect in the cycle it is sampled; the next edge yields `sum_in_en` = 0.
- `fifo_count` reflects the state after each edge:
  - push only: +1
  - pop only: −1
  - both: 0

## Test plan

- **Reset behaviour:** assert `arst` mid-cycle with `fifo_count` = 2 → all outputs 0 immediately, `op_in_ready` = 0; after release `op_in_ready` = 1 and `fifo_count` = 0.
- **Single pair:** send A = 0x0000_0005 then B = 0x0000_0003 → one cycle after the B handshake `sum_in_en` = 1 with `sum_in1` = 5, `sum_in2` = 3; `sum_in_en` drops the next cycle. The downstream adder gives `sum_out` = 8.
- **Fill and stall:** `issue_hold` = 1, stream 5 pairs (`FIFO_DEPTH` = 4):
  - after 4 pairs, `fifo_count` = 4;
  - the 5th A is accepted;
  - the 5th B sees `op_in_ready` = 0.
  
  Release `issue_hold` → `op_in_ready` = 1 the same cycle, B pushed, then 5 issues in order on consecutive cycles with pairs intact.
- **Pointer wrap:** 12 pairs with random `issue_hold` toggling → the issued sequence matches the input order exactly; `fifo_count` never exceeds 4.
- **Clear mid-pair:** accept A = 0xDEAD_BEEF with 2 pairs buffered, pulse `op_clear` → next cycle `fifo_count` = 0, `sum_in_en` = 0, state `S_A`. A following 0x1 / 0x2 pair issues as `sum_in1` = 1, `sum_in2` = 2, not 0xDEAD_BEEF.
- **Simultaneous push/pop at full:** `fifo_count` = 4, `issue_hold` = 0, B presented → push accepted, `fifo_count` stays 4, and the popped pair is the oldest.

Source files
------------

// File: rtl/sum_operand_feeder_if.sv
// rtl/sum_operand_feeder_if.sv - operand stream and adder-feed signal bundle
// The producer drives through master; the feeder sits on slave.
interface sum_operand_feeder_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
);
  logic [BUS_WIDTH-1:0]             op_in;
  logic                             op_in_valid;
  logic                             op_in_ready;
  logic                             op_clear;
  logic                             issue_hold;
  logic [BUS_WIDTH-1:0]             sum_in1;
  logic [BUS_WIDTH-1:0]             sum_in2;
  logic                             sum_in_en;
  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count;

  modport master (
    output op_in, op_in_valid, op_clear, issue_hold,
    input  op_in_ready, sum_in1, sum_in2, sum_in_en, fifo_count
  );

  modport slave (
    input  op_in, op_in_valid, op_clear, issue_hold,
    output op_in_ready, sum_in1, sum_in2, sum_in_en, fifo_count
  );
endinterface

// File: rtl/sum_operand_feeder.sv
// rtl/sum_operand_feeder.sv - pairs an A,B operand stream and feeds the registered adder
// Pairs are buffered in a small FIFO and issued at most one per cycle.
module sum_operand_feeder #(
  parameter int BUS_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  sum_operand_feeder_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_A, S_B} state_t;

  state_t                 state, state_nxt;
  logic [BUS_WIDTH-1:0]   a_reg;
  logic [2*BUS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [BUS_WIDTH-1:0]   sum_in1_q, sum_in2_q;
  logic                   sum_in_en_q;
  logic                   full, empty, pop, push, capture_a, ready, xfer;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && !bus.issue_hold && !bus.op_clear;

  // A full FIFO can still take B when the head leaves in the same cycle.
  assign ready = !arst && !bus.op_clear && ((state == S_A) || !full || pop);
  assign xfer  = bus.op_in_valid && ready;

  always_comb begin
    state_nxt = state;
    capture_a = 1'b0;
    push      = 1'b0;
    if (bus.op_clear) begin
      state_nxt = S_A;
    end else if (xfer) begin
      if (state == S_A) begin
        capture_a = 1'b1;
        state_nxt = S_B;
      end else begin
        push      = 1'b1;
        state_nxt = S_A;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= S_A;
      a_reg       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      sum_in1_q   <= '0;
      sum_in2_q   <= '0;
      sum_in_en_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture_a) begin
        a_reg <= bus.op_in;
      end
      if (bus.op_clear) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        sum_in_en_q <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr    <= rd_ptr + PTR_W'(1);
          sum_in1_q <= mem[rd_ptr][2*BUS_WIDTH-1:BUS_WIDTH];
          sum_in2_q <= mem[rd_ptr][BUS_WIDTH-1:0];
        end
        sum_in_en_q <= pop;
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Storage needs no reset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {a_reg, bus.op_in};
    end
  end

  assign bus.op_in_ready = ready;
  assign bus.sum_in1     = sum_in1_q;
  assign bus.sum_in2     = sum_in2_q;
  assign bus.sum_in_en   = sum_in_en_q;
  assign bus.fifo_count  = count;
endmodule

// File: tb/tb_sum_operand_feeder.sv
// tb/tb_sum_operand_feeder.sv - bench for sum_operand_feeder
// Per-cycle vector table followed by reset, clear and pointer-wrap sequences.
module tb_sum_operand_feeder;
  logic clk;
  logic arst;
  int   checks;
  int   failures;

  sum_operand_feeder_if #(.BUS_WIDTH(32), .FIFO_DEPTH(4)) bus ();

  sum_operand_feeder #(.BUS_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] op;
    logic        hold;
    logic        exp_ready;
    logic        exp_en;
    logic [31:0] exp_in1;
    logic [31:0] exp_in2;
    logic [2:0]  exp_count;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  logic [63:0] exp_q [$];
  int          issued;

  function automatic vec_t mk(input logic v, input logic [31:0] op, input logic h,
                              input logic r, input logic e, input logic [31:0] i1,
                              input logic [31:0] i2, input logic [2:0] c);
    vec_t t;
    t.valid = v; t.op = op; t.hold = h; t.exp_ready = r;
    t.exp_en = e; t.exp_in1 = i1; t.exp_in2 = i2; t.exp_count = c;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input string name);
    int   guard;
    logic acc;
    bus.op_in       = w;
    bus.op_in_valid = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 20) begin
      #1;
      acc = bus.op_in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.op_in_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL %s: op_in_ready got 0 for 20 cycles expected 1", name);
    end
  endtask

  task automatic observe();
    logic [63:0] e;
    if (bus.sum_in_en) begin
      issued++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wrap_issue: got unexpected pair %0h/%0h expected none", bus.sum_in1, bus.sum_in2);
      end else begin
        e = exp_q.pop_front();
        if ({bus.sum_in1, bus.sum_in2} !== e) begin
          failures++;
          $display("FAIL wrap_issue: got %0h/%0h expected %0h/%0h",
                   bus.sum_in1, bus.sum_in2, e[63:32], e[31:0]);
        end
      end
    end
  endtask

  // FIFO occupancy must never exceed its depth.
  always @(negedge clk) begin
    if (!arst) begin
      checks++;
      if (bus.fifo_count > 3'd4) begin
        failures++;
        $display("FAIL fifo_bound: got count %0d expected <= 4", bus.fifo_count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    issued   = 0;

    tbl[0]  = mk(1, 32'h5,   0, 1, 0, 32'h0,   32'h0,   3'd0);
    tbl[1]  = mk(1, 32'h3,   0, 1, 0, 32'h0,   32'h0,   3'd1);
    tbl[2]  = mk(0, 32'h0,   0, 1, 1, 32'h5,   32'h3,   3'd0);
    tbl[3]  = mk(0, 32'h0,   0, 1, 0, 32'h5,   32'h3,   3'd0);
    tbl[4]  = mk(1, 32'h10,  1, 1, 0, 32'h5,   32'h3,   3'd0);
    tbl[5]  = mk(1, 32'h11,  1, 1, 0, 32'h5,   32'h3,   3'd1);
    tbl[6]  = mk(1, 32'h20,  1, 1, 0, 32'h5,   32'h3,   3'd1);
    tbl[7]  = mk(1, 32'h21,  1, 1, 0, 32'h5,   32'h3,   3'd2);
    tbl[8]  = mk(1, 32'h30,  1, 1, 0, 32'h5,   32'h3,   3'd2);
    tbl[9]  = mk(1, 32'h31,  1, 1, 0, 32'h5,   32'h3,   3'd3);
    tbl[10] = mk(1, 32'h40,  1, 1, 0, 32'h5,   32'h3,   3'd3);
    tbl[11] = mk(1, 32'h41,  1, 1, 0, 32'h5,   32'h3,   3'd4);
    tbl[12] = mk(1, 32'h50,  1, 1, 0, 32'h5,   32'h3,   3'd4);
    tbl[13] = mk(1, 32'h51,  1, 0, 0, 32'h5,   32'h3,   3'd4);
    tbl[14] = mk(1, 32'h51,  0, 1, 1, 32'h10,  32'h11,  3'd4);
    tbl[15] = mk(0, 32'h0,   0, 1, 1, 32'h20,  32'h21,  3'd3);
    tbl[16] = mk(0, 32'h0,   0, 1, 1, 32'h30,  32'h31,  3'd2);
    tbl[17] = mk(0, 32'h0,   0, 1, 1, 32'h40,  32'h41,  3'd1);
    tbl[18] = mk(0, 32'h0,   0, 1, 1, 32'h50,  32'h51,  3'd0);
    tbl[19] = mk(0, 32'h0,   0, 1, 0, 32'h50,  32'h51,  3'd0);
    tbl[20] = mk(1, 32'h100, 0, 1, 0, 32'h50,  32'h51,  3'd0);
    tbl[21] = mk(1, 32'h101, 0, 1, 0, 32'h50,  32'h51,  3'd1);
    tbl[22] = mk(1, 32'h200, 0, 1, 1, 32'h100, 32'h101, 3'd0);
    tbl[23] = mk(1, 32'h201, 0, 1, 0, 32'h100, 32'h101, 3'd1);
    tbl[24] = mk(0, 32'h0,   0, 1, 1, 32'h200, 32'h201, 3'd0);
    tbl[25] = mk(0, 32'h0,   0, 1, 0, 32'h200, 32'h201, 3'd0);

    arst            = 1'b1;
    bus.op_in       = '0;
    bus.op_in_valid = 1'b0;
    bus.op_clear    = 1'b0;
    bus.issue_hold  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.op_in_ready, 0);
    chk("rst_en",    bus.sum_in_en,   0);
    chk("rst_count", bus.fifo_count,  0);
    chk("rst_in1",   bus.sum_in1,     0);
    chk("rst_in2",   bus.sum_in2,     0);
    arst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      bus.op_in_valid = tbl[i].valid;
      bus.op_in       = tbl[i].op;
      bus.issue_hold  = tbl[i].hold;
      #1;
      chk($sformatf("v%0d_ready", i), bus.op_in_ready, tbl[i].exp_ready);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_en", i),    bus.sum_in_en,  tbl[i].exp_en);
      chk($sformatf("v%0d_in1", i),   bus.sum_in1,    tbl[i].exp_in1);
      chk($sformatf("v%0d_in2", i),   bus.sum_in2,    tbl[i].exp_in2);
      chk($sformatf("v%0d_count", i), bus.fifo_count, tbl[i].exp_count);
    end
    bus.op_in_valid = 1'b0;

    // Reset mid-cycle with two pairs buffered and an A half-captured.
    bus.issue_hold = 1'b1;
    send_word(32'h81, "rs_a0"); send_word(32'h82, "rs_b0");
    send_word(32'h91, "rs_a1"); send_word(32'h92, "rs_b1");
    send_word(32'hAA, "rs_a2");
    chk("rs_pre_count", bus.fifo_count, 2);
    bus.op_in_valid = 1'b1;
    bus.op_in       = 32'hBB;
    #2;
    arst = 1'b1;
    #1;
    chk("rs_ready", bus.op_in_ready, 0);
    chk("rs_en",    bus.sum_in_en,   0);
    chk("rs_count", bus.fifo_count,  0);
    chk("rs_in1",   bus.sum_in1,     0);
    chk("rs_in2",   bus.sum_in2,     0);
    @(posedge clk);
    #1;
    chk("rs_hold_ready", bus.op_in_ready, 0);
    arst            = 1'b0;
    bus.op_in_valid = 1'b0;
    #1;
    chk("rs_rel_ready", bus.op_in_ready, 1);
    chk("rs_rel_count", bus.fifo_count,  0);
    @(posedge clk);
    #1;
    bus.issue_hold = 1'b0;
    send_word(32'h7, "rs_a3");
    send_word(32'h9, "rs_b3");
    @(posedge clk);
    #1;
    chk("rs_post_en",  bus.sum_in_en, 1);
    chk("rs_post_in1", bus.sum_in1,   32'h7);
    chk("rs_post_in2", bus.sum_in2,   32'h9);

    // Clear with two pairs buffered and A = DEADBEEF waiting for its B.
    bus.issue_hold = 1'b1;
    send_word(32'h61, "cl_a0"); send_word(32'h62, "cl_b0");
    send_word(32'h71, "cl_a1"); send_word(32'h72, "cl_b1");
    send_word(32'hDEADBEEF, "cl_a2");
    chk("cl_pre_count", bus.fifo_count, 2);
    bus.issue_hold  = 1'b0;
    bus.op_clear    = 1'b1;
    bus.op_in_valid = 1'b1;
    bus.op_in       = 32'h55;
    #1;
    chk("cl_ready", bus.op_in_ready, 0);
    @(posedge clk);
    #1;
    chk("cl_count", bus.fifo_count, 0);
    chk("cl_en",    bus.sum_in_en,  0);
    chk("cl_in1",   bus.sum_in1,    32'h7);
    chk("cl_in2",   bus.sum_in2,    32'h9);
    bus.op_clear    = 1'b0;
    bus.op_in_valid = 1'b0;
    send_word(32'h1, "cl_a3");
    send_word(32'h2, "cl_b3");
    chk("cl_push_count", bus.fifo_count, 1);
    @(posedge clk);
    #1;
    chk("cl_post_en",  bus.sum_in_en, 1);
    chk("cl_post_in1", bus.sum_in1,   32'h1);
    chk("cl_post_in2", bus.sum_in2,   32'h2);
    @(posedge clk);
    #1;

    // Twelve pairs with random issue_hold exercise pointer wrap.
    exp_q.delete();
    issued = 0;
    for (int p = 0; p < 12; p++) begin
      for (int w = 0; w < 2; w++) begin
        int   guard;
        logic acc;
        bus.op_in       = (w == 0) ? (32'hA000 + p) : (32'hB000 + p);
        bus.op_in_valid = 1'b1;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
          bus.issue_hold = 1'($urandom_range(0, 1));
          #1;
          acc = bus.op_in_ready;
          @(posedge clk);
          #1;
          observe();
          guard++;
        end
        checks++;
        if (!acc) begin
          failures++;
          $display("FAIL wrap_accept: op_in_ready got 0 for 50 cycles expected 1");
        end
        if (w == 1) exp_q.push_back({32'hA000 + p, 32'hB000 + p});
      end
    end
    bus.op_in_valid = 1'b0;
    bus.issue_hold  = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
      observe();
    end
    chk("wrap_left",   exp_q.size(), 0);
    chk("wrap_issued", issued,       12);
    chk("wrap_count",  bus.fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
